// File: rtl/arm_decode_stage_pkg.sv
// Shared types for the ARM decode stage: instruction class, condition/ALU opcode types,
// the decoded-field bundle and the BX match constant.
package arm_decode_stage_pkg;

  typedef enum logic [2:0] {
    CLS_DATA_PROC = 3'd0,
    CLS_MUL       = 3'd1,
    CLS_MUL_LONG  = 3'd2,
    CLS_SWAP      = 3'd3,
    CLS_BX        = 3'd4,
    CLS_HALF_IMM  = 3'd5,
    CLS_HALF_REG  = 3'd6,
    CLS_OTHER     = 3'd7
  } instr_class_e;

  typedef logic [3:0] cond_t;
  typedef logic [3:0] alu_op_t;

  localparam cond_t       COND_AL  = 4'hE;
  // Bits [27:4] of a BX instruction.
  localparam logic [23:0] BX_MATCH = 24'h12FFF1;

  typedef struct packed {
    instr_class_e cls;
    cond_t        cond;
    logic [3:0]   rn;
    logic [3:0]   rd;
    logic [3:0]   rs;
    logic [3:0]   rm;
    alu_op_t      alu_op;
    logic [3:0]   rotate;
    logic [7:0]   imm;
    logic         set_cond;
  } decoded_t;

endpackage

// File: rtl/arm_instr_classifier.sv
// Combinational classifier and field extractor for one instruction word.
// Thumb ALU-format decode is added when THUMB_DECODE_EN is defined.
module arm_instr_classifier
  import arm_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
`ifdef THUMB_DECODE_EN
  input  logic        thumb,
`endif
  output decoded_t    dec
);

  always_comb begin
    // NOTE: every field is assigned before any branch so no latch can be inferred.
    dec.cls      = CLS_DATA_PROC;
    dec.cond     = instr[31:28];
    dec.rn       = instr[19:16];
    dec.rd       = instr[15:12];
    dec.rs       = instr[11:8];
    dec.rm       = instr[3:0];
    dec.alu_op   = instr[24:21];
    dec.set_cond = instr[20];
    dec.imm      = instr[7:0];
    dec.rotate   = instr[11:8];

    // First matching rule wins; ordering resolves the overlapping encodings.
    if (instr[27:26] != 2'b00)
      dec.cls = CLS_OTHER;
    else if (instr[25:22] == 4'b0000 && instr[7:4] == 4'b1001)
      dec.cls = CLS_MUL;
    else if (instr[25:23] == 3'b001 && instr[7:4] == 4'b1001)
      dec.cls = CLS_MUL_LONG;
    else if (instr[27:4] == BX_MATCH)
      dec.cls = CLS_BX;
    else if (instr[25:23] == 3'b010 && instr[21:20] == 2'b00 && instr[11:4] == 8'h09)
      dec.cls = CLS_SWAP;
    else if (!instr[22] && instr[11:7] == 5'b00001 && instr[4])
      dec.cls = CLS_HALF_REG;
    else if (instr[22] && instr[7] && instr[4])
      dec.cls = CLS_HALF_IMM;

`ifdef THUMB_DECODE_EN
    if (thumb) begin
      dec.cond = COND_AL;
      if (instr[15:10] == 6'b010000) begin
        dec.cls      = CLS_DATA_PROC;
        dec.alu_op   = instr[9:6];
        dec.rd       = {1'b0, instr[2:0]};
        dec.rn       = {1'b0, instr[2:0]};
        dec.rm       = {1'b0, instr[5:3]};
        dec.set_cond = 1'b1;
      end else begin
        dec.cls = CLS_OTHER;
      end
    end
`endif
  end

endmodule

// File: rtl/arm_decode_stage.sv
// Decode stage: circular {instr, pc} queue feeding one decoded output register.
// Optional THUMB_DECODE_EN adds a per-entry thumb_mode bit and Thumb ALU decode.
module arm_decode_stage
  import arm_decode_stage_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int PC_W        = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [31:0]                      in_instr,
  input  logic [PC_W-1:0]                  in_pc,
`ifdef THUMB_DECODE_EN
  input  logic                             thumb_mode,
`endif
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2:0]                       out_class,
  output logic [3:0]                       out_cond,
  output logic [3:0]                       out_rn,
  output logic [3:0]                       out_rd,
  output logic [3:0]                       out_rs,
  output logic [3:0]                       out_rm,
  output logic [3:0]                       out_alu_op,
  output logic [3:0]                       out_rotate,
  output logic [7:0]                       out_imm,
  output logic                             out_set_cond,
  output logic [31:0]                      out_instr,
  output logic [PC_W-1:0]                  out_pc,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy
);

  localparam int               PTR_W    = $clog2(QUEUE_DEPTH);
  localparam int               OCC_W    = $clog2(QUEUE_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(QUEUE_DEPTH);

  logic [31:0]      instr_mem_q [QUEUE_DEPTH];
  logic [PC_W-1:0]  pc_mem_q    [QUEUE_DEPTH];
`ifdef THUMB_DECODE_EN
  logic             thumb_mem_q [QUEUE_DEPTH];
  logic             head_thumb;
`endif

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             out_valid_q, out_valid_d;
  decoded_t         out_dec_q, out_dec_d, head_dec;
  logic [31:0]      out_instr_q, out_instr_d, head_instr;
  logic [PC_W-1:0]  out_pc_q, out_pc_d, head_pc;
  logic             q_empty, push, take, q_write, q_read;

  // An empty queue presents the incoming word as its head, giving one-cycle latency.
  always_comb begin
    q_empty    = (occ_q == '0);
    head_instr = q_empty ? in_instr : instr_mem_q[rd_ptr_q];
    head_pc    = q_empty ? in_pc    : pc_mem_q[rd_ptr_q];
`ifdef THUMB_DECODE_EN
    head_thumb = q_empty ? thumb_mode : thumb_mem_q[rd_ptr_q];
`endif
  end

  arm_instr_classifier u_classifier (
    .instr (head_instr),
`ifdef THUMB_DECODE_EN
    .thumb (head_thumb),
`endif
    .dec   (head_dec)
  );

  always_comb begin
    in_ready = !reset && (occ_q < OCC_FULL);
    push     = in_valid && in_ready && !flush;
    take     = (!q_empty || push) && (!out_valid_q || out_ready) && !flush;
    q_read   = take && !q_empty;
    q_write  = push && !(take && q_empty);

    wr_ptr_d    = wr_ptr_q + PTR_W'(q_write);
    rd_ptr_d    = rd_ptr_q + PTR_W'(q_read);
    occ_d       = occ_q + OCC_W'(q_write) - OCC_W'(q_read);
    out_valid_d = out_valid_q && !out_ready;
    out_dec_d   = out_dec_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    if (take) begin
      out_valid_d = 1'b1;
      out_dec_d   = head_dec;
      out_instr_d = head_instr;
      out_pc_d    = head_pc;
    end

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_dec_q   <= '0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_dec_q   <= out_dec_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // NOTE: queue storage is not reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (q_write) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
`ifdef THUMB_DECODE_EN
      thumb_mem_q[wr_ptr_q] <= thumb_mode;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_class    = out_dec_q.cls;
  assign out_cond     = out_dec_q.cond;
  assign out_rn       = out_dec_q.rn;
  assign out_rd       = out_dec_q.rd;
  assign out_rs       = out_dec_q.rs;
  assign out_rm       = out_dec_q.rm;
  assign out_alu_op   = out_dec_q.alu_op;
  assign out_rotate   = out_dec_q.rotate;
  assign out_imm      = out_dec_q.imm;
  assign out_set_cond = out_dec_q.set_cond;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign occupancy    = occ_q;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Self-checking bench for arm_decode_stage: directed scenarios plus randomized traffic
// against a model that treats the stage as one in-order list of DEPTH+1 pending items.
module tb_arm_decode_stage;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready, flush, out_valid, out_ready, thumb_mode;
  logic [31:0]     in_instr, out_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [2:0]      out_class;
  logic [3:0]      out_cond, out_rn, out_rd, out_rs, out_rm, out_alu_op, out_rotate;
  logic [7:0]      out_imm;
  logic            out_set_cond;
  logic [2:0]      occupancy;

  always #5 clk = ~clk;

  arm_decode_stage #(.QUEUE_DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
`ifdef THUMB_DECODE_EN
    .thumb_mode   (thumb_mode),
`endif
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_class    (out_class),
    .out_cond     (out_cond),
    .out_rn       (out_rn),
    .out_rd       (out_rd),
    .out_rs       (out_rs),
    .out_rm       (out_rm),
    .out_alu_op   (out_alu_op),
    .out_rotate   (out_rotate),
    .out_imm      (out_imm),
    .out_set_cond (out_set_cond),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .occupancy    (occupancy)
  );

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic            thumb;
  } item_t;

  item_t        pend[$];   // accepted, not yet consumed; front is what the output shows
  logic [103:0] exp_view;  // {class, cond, rn, rd, rs, rm, alu, rot, imm, set, instr, pc}
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Mask/value table form of the classification rules, scanned in priority order.
  function automatic logic [39:0] ref_decode(input logic [31:0] w, input logic thumb);
    logic [2:0] c;
    logic [3:0] cond, rn, rd, rs, rm, alu, rot;
    logic [7:0] imm;
    logic       s;
    cond = w[31:28]; rn = w[19:16]; rd = w[15:12]; rs = w[11:8]; rm = w[3:0];
    alu = w[24:21]; s = w[20]; imm = w[7:0]; rot = w[11:8];
    if ((w & 32'h0C000000) != 32'h0)                  c = 3'd7;
    else if ((w & 32'h03C000F0) == 32'h00000090)      c = 3'd1;
    else if ((w & 32'h038000F0) == 32'h00800090)      c = 3'd2;
    else if ((w & 32'h0FFFFFF0) == 32'h012FFF10)      c = 3'd4;
    else if ((w & 32'h03B00FF0) == 32'h01000090)      c = 3'd3;
    else if ((w & 32'h00400F90) == 32'h00000090)      c = 3'd6;
    else if ((w & 32'h00400090) == 32'h00400090)      c = 3'd5;
    else                                              c = 3'd0;
    if (thumb) begin
      cond = 4'hE;
      if ((w & 32'h0000FC00) == 32'h00004000) begin
        c = 3'd0; alu = w[9:6]; rd = {1'b0, w[2:0]}; rn = rd; rm = {1'b0, w[5:3]}; s = 1'b1;
      end else begin
        c = 3'd7;
      end
    end
    return {c, cond, rn, rd, rs, rm, alu, rot, imm, s};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r, mask, val;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       begin mask = 32'h03C000F0; val = 32'h00000090; end
      1:       begin mask = 32'h038000F0; val = 32'h00800090; end
      2:       begin mask = 32'h0FFFFFF0; val = 32'h012FFF10; end
      3:       begin mask = 32'h03B00FF0; val = 32'h01000090; end
      4:       begin mask = 32'h00400F90; val = 32'h00000090; end
      5:       begin mask = 32'h00400090; val = 32'h00400090; end
      6:       begin mask = 32'h0000FC00; val = 32'h00004000; end
      default: begin mask = 32'h0;        val = 32'h0;        end
    endcase
    if ($urandom_range(0, 3) != 0) r[27:26] = 2'b00;
    return (r & ~mask) | val;
  endfunction

  // One clock: check in_ready mid-cycle, advance the model at the edge, check outputs after it.
  task automatic tick();
    logic        exp_rdy;
    logic [39:0] d;
    item_t       it;
    exp_rdy = !reset && (pend.size() <= DEPTH);
    @(negedge clk);
    check("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (reset) begin
      pend.delete();
      exp_view = '0;
    end else if (flush) begin
      pend.delete();
    end else begin
      if (pend.size() > 0 && out_ready) void'(pend.pop_front());
      if (in_valid && exp_rdy) begin
        it.instr = in_instr; it.pc = in_pc; it.thumb = thumb_mode;
        pend.push_back(it);
      end
    end
    if (pend.size() > 0) begin
      d = ref_decode(pend[0].instr, pend[0].thumb);
      exp_view = {d, pend[0].instr, pend[0].pc};
    end
    #1;
    check("out_valid", out_valid, pend.size() > 0);
    check("occupancy", occupancy, (pend.size() > 0) ? pend.size() - 1 : 0);
    check("out_class", out_class, exp_view[103:101]);
    check("out_fields", {out_cond, out_rn, out_rd, out_rs, out_rm, out_alu_op, out_rotate,
                         out_imm, out_set_cond, out_instr, out_pc}, exp_view[100:0]);
  endtask

  logic [31:0] seq_instr [4];
  logic [2:0]  seq_class [4];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0; thumb_mode = 1'b0; exp_view = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post_reset_ready", in_ready, 1'b1);

    // Single data-processing instruction, one-cycle latency.
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hE0812003; in_pc = 32'h0000_0100;
    tick();
    in_valid = 1'b0;
    check("dp_valid", out_valid, 1'b1);
    check("dp_class", out_class, 3'd0);
    check("dp_fields", {out_cond, out_rn, out_rd, out_rm, out_alu_op, out_set_cond},
          {4'hE, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0});
    tick();

    // Back-to-back stream with the consumer always ready: no bubbles.
    seq_instr[0] = 32'hE0010392; seq_class[0] = 3'd1;
    seq_instr[1] = 32'hE0810392; seq_class[1] = 3'd2;
    seq_instr[2] = 32'hE12FFF10; seq_class[2] = 3'd4;
    seq_instr[3] = 32'hE1020091; seq_class[3] = 3'd3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = seq_instr[i]; in_pc = 32'h200 + 32'(4 * i);
      tick();
      check("stream_valid", out_valid, 1'b1);
      check("stream_class", out_class, seq_class[i]);
    end
    in_valid = 1'b0;
    tick();

    // Fill with consumer stalled: five accepted, sixth refused.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = 32'hE0812003 + 32'(i); in_pc = 32'h300 + 32'(4 * i);
      tick();
    end
    check("full_occupancy", occupancy, 3'd4);
    check("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("after_pop_ready", in_ready, 1'b1);
    check("after_pop_occupancy", occupancy, 3'd3);

    // Flush at occupancy 3 with a push offered in the same cycle.
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_instr = 32'hE1020091;
    tick();
    check("flush_occupancy", occupancy, 3'd0);
    check("flush_valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("flush_push_dropped", out_valid, 1'b0);

    // Reset while holding entries, then a halfword-immediate transfer.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 32'hE0010392; in_pc = 32'h400 + 32'(4 * i);
      tick();
    end
    check("pre_reset_occupancy", occupancy, 3'd2);
    in_valid = 1'b0; reset = 1'b1;
    tick();
    check("reset_outputs", {out_valid, occupancy, out_class, out_cond, out_rn, out_rd, out_instr},
          '0);
    reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hE1D000B2; in_pc = 32'h500;
    tick();
    in_valid = 1'b0;
    check("halfimm_class", out_class, 3'd5);
    tick();

`ifdef THUMB_DECODE_EN
    thumb_mode = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_4008; in_pc = 32'h600;
    tick();
    in_valid = 1'b0; thumb_mode = 1'b0;
    check("thumb_class", out_class, 3'd0);
    check("thumb_fields", {out_alu_op, out_rd, out_rm}, {4'h0, 4'h0, 4'h1});
    tick();
`endif

    // Randomized traffic; alternating phases stall the consumer to exercise a full queue.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      out_ready = ((n / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 127) == 0);
`ifdef THUMB_DECODE_EN
      thumb_mode = $urandom_range(0, 1) == 1;
`endif
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
